// File: rtl/spmem_pkj.sv
// Shared types for the sparse memory model and its request front-ends.
// Widths are fixed here; users import them rather than re-declaring.
package spmem_pkj;

  localparam int AddrWidth = 32;
  localparam int DataWidth = 64;
  localparam int LineBytes = DataWidth / 8;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [LineBytes-1:0] be_t;

  typedef enum logic [1:0] {
    RW_BYTE  = 2'd0,
    RW_HALF  = 2'd1,
    RW_WORD  = 2'd2,
    RW_DWORD = 2'd3
  } rwop_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } spsplit_state_e;

  // Byte-enable pattern of an access before it is shifted into its lane.
  function automatic be_t op_be(input rwop_e op);
    case (op)
      RW_BYTE: return 8'h01;
      RW_HALF: return 8'h03;
      RW_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/spmem_load_align.sv
// Extracts a sized load from a two-line window {hi,lo} at byte offset off
// and zero- or sign-extends it to a full data word.
module spmem_load_align
  import spmem_pkj::*;
(
  input  logic [2*DataWidth-1:0] line,
  input  logic [2:0]             off,
  input  rwop_e                  op,
  input  logic                   load_unsigned,
  output data_t                  rdata
);

  data_t shifted;

  assign shifted = DataWidth'(line >> {off, 3'b000});

  always_comb begin
    rdata = shifted;
    case (op)
      RW_BYTE: rdata = {{56{!load_unsigned && shifted[7]}}, shifted[7:0]};
      RW_HALF: rdata = {{48{!load_unsigned && shifted[15]}}, shifted[15:0]};
      RW_WORD: rdata = {{32{!load_unsigned && shifted[31]}}, shifted[31:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/spmem_access_splitter.sv
// Turns one sized, arbitrarily aligned load/store into one or two aligned
// memory beats and returns a single merged, extended response.
module spmem_access_splitter
  import spmem_pkj::*;
#(
  parameter bit AllowSplit = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  req_valid,
  output logic  req_ready,
  input  addr_t req_addr,
  input  rwop_e req_op,
  input  logic  req_we,
  input  logic  req_unsigned,
  input  data_t req_wdata,
  output logic  rsp_valid,
  input  logic  rsp_ready,
  output data_t rsp_rdata,
  output logic  rsp_err,
  output logic  mem_valid,
  input  logic  mem_ready,
  output addr_t mem_addr,
  output logic  mem_we,
  output be_t   mem_be,
  output data_t mem_wdata,
  input  logic  mem_rvalid,
  input  data_t mem_rdata,
  output logic  err_unexp
);

  spsplit_state_e state, state_nxt;

  addr_t                  h_addr;
  rwop_e                  h_op;
  logic                   h_we, h_uns, h_cross, h_err;
  logic [2*LineBytes-1:0] h_mask;
  logic [2*DataWidth-1:0] h_wide;
  data_t                  lo, hi, load_data;

  logic [2:0] req_off;
  logic [3:0] req_size;
  logic       req_cross, accept;
  addr_t      line_addr;

  assign req_off   = req_addr[2:0];
  assign req_size  = 4'd1 << req_op;
  assign req_cross = ({1'b0, req_off} + req_size) > 4'd8;
  assign accept    = req_valid && (state == IDLE);
  assign line_addr = {h_addr[AddrWidth-1:3], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (req_cross && !AllowSplit) ? RESP : ISSUE0;
      ISSUE0:  if (mem_ready) state_nxt = !h_we ? WAIT0 : (h_cross ? ISSUE1 : RESP);
      WAIT0:   if (mem_rvalid) state_nxt = h_cross ? ISSUE1 : RESP;
      ISSUE1:  if (mem_ready) state_nxt = h_we ? RESP : WAIT1;
      WAIT1:   if (mem_rvalid) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is decoded once into lane-positioned mask and data spanning two lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_addr  <= '0;
      h_op    <= RW_BYTE;
      h_we    <= 1'b0;
      h_uns   <= 1'b0;
      h_cross <= 1'b0;
      h_err   <= 1'b0;
      h_mask  <= '0;
      h_wide  <= '0;
    end else if (accept) begin
      h_addr  <= req_addr;
      h_op    <= req_op;
      h_we    <= req_we;
      h_uns   <= req_unsigned;
      h_cross <= req_cross;
      h_err   <= req_cross && !AllowSplit;
      h_mask  <= {8'h00, op_be(req_op)} << req_off;
      h_wide  <= {{DataWidth{1'b0}}, req_wdata} << {req_off, 3'b000};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo        <= '0;
      hi        <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (state == WAIT0 && mem_rvalid) lo <= mem_rdata;
      if (state == WAIT1 && mem_rvalid) hi <= mem_rdata;
      if (mem_rvalid && state != WAIT0 && state != WAIT1) err_unexp <= 1'b1;
    end
  end

  spmem_load_align u_align (
    .line         ({hi, lo}),
    .off          (h_addr[2:0]),
    .op           (h_op),
    .load_unsigned(h_uns),
    .rdata        (load_data)
  );

  // Every output is a pure function of state and holding registers, so it stays put while stalled.
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      ISSUE0: begin
        mem_valid = 1'b1;
        mem_addr  = line_addr;
        mem_we    = h_we;
        mem_be    = h_mask[LineBytes-1:0];
        mem_wdata = h_wide[DataWidth-1:0];
      end
      ISSUE1: begin
        mem_valid = 1'b1;
        mem_addr  = line_addr + AddrWidth'(LineBytes);
        mem_we    = h_we;
        mem_be    = h_mask[2*LineBytes-1:LineBytes];
        mem_wdata = h_wide[2*DataWidth-1:DataWidth];
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = h_err;
        rsp_rdata = (h_we || h_err) ? '0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spmem_access_splitter.sv
// Scoreboard bench for spmem_access_splitter: a byte-level reference model
// predicts beats and responses; independent monitors pop and compare them.
module tb_spmem_access_splitter;
  import spmem_pkj::*;

  typedef struct {
    addr_t addr;
    logic  we;
    be_t   be;
    data_t wdata;
    logic  second;
  } beat_t;

  typedef struct {
    data_t rdata;
    logic  err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic  req_valid, req_ready, req_we, req_unsigned;
  addr_t req_addr;
  rwop_e req_op;
  data_t req_wdata;
  logic  rsp_valid, rsp_ready, rsp_err;
  data_t rsp_rdata;
  logic  mem_valid, mem_ready, mem_we, mem_rvalid, err_unexp;
  addr_t mem_addr;
  be_t   mem_be;
  data_t mem_wdata, mem_rdata;

  logic  n_req_valid, n_req_ready, n_req_we, n_rsp_valid, n_rsp_ready, n_rsp_err;
  addr_t n_req_addr, n_mem_addr;
  rwop_e n_req_op;
  data_t n_req_wdata, n_rsp_rdata, n_mem_wdata;
  logic  n_mem_valid, n_mem_we, n_err_unexp;
  be_t   n_mem_be;

  spmem_access_splitter #(.AllowSplit(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
    .req_we(req_we), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_unexp(err_unexp)
  );

  spmem_access_splitter #(.AllowSplit(1'b0)) dut_nosplit (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_addr(n_req_addr), .req_op(n_req_op),
    .req_we(n_req_we), .req_unsigned(1'b0), .req_wdata(n_req_wdata),
    .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err),
    .mem_valid(n_mem_valid), .mem_ready(1'b1), .mem_addr(n_mem_addr), .mem_we(n_mem_we),
    .mem_be(n_mem_be), .mem_wdata(n_mem_wdata), .mem_rvalid(1'b0), .mem_rdata(64'h0),
    .err_unexp(n_err_unexp)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int beat1_loads = 0;
  int stray_req = 0;
  int mem_stall_cfg = 0;
  int rsp_stall_cfg = 0;
  bit zero_wait = 1'b0;
  bit hold_beat1 = 1'b0;
  bit n_mem_seen = 1'b0;

  beat_t exp_beats[$];
  rsp_t  exp_rsp[$];
  logic [7:0] ref_mem[addr_t];
  logic [7:0] sim_mem[addr_t];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fill_byte(input addr_t a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_byte(input addr_t a);
    return ref_mem.exists(a) ? ref_mem[a] : fill_byte(a);
  endfunction

  function automatic logic [7:0] sim_byte(input addr_t a);
    return sim_mem.exists(a) ? sim_mem[a] : fill_byte(a);
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model works byte by byte: which bytes of which line are touched, and their values.
  task automatic apply_stimulus(input addr_t addr, input rwop_e op, input logic we,
                                input logic uns, input data_t wdata, input bit wait_done);
    int size;
    int budget;
    logic [2:0] off;
    be_t be0, be1;
    logic [127:0] wide;
    data_t val;
    addr_t a;
    beat_t b;
    rsp_t r;
    size = 1 << op;
    off  = addr[2:0];
    be0  = '0;
    be1  = '0;
    for (int i = 0; i < size; i++) begin
      int p;
      p = int'(off) + i;
      if (p < 8) be0[p] = 1'b1;
      else be1[p-8] = 1'b1;
    end
    wide = {64'h0, wdata} << (8 * int'(off));
    b.addr = {addr[31:3], 3'b000};
    b.we = we; b.be = be0; b.wdata = wide[63:0]; b.second = 1'b0;
    exp_beats.push_back(b);
    if (be1 != 8'h00) begin
      b.addr = b.addr + 32'd8;
      b.be = be1; b.wdata = wide[127:64]; b.second = 1'b1;
      exp_beats.push_back(b);
    end
    val = '0;
    for (int i = 0; i < size; i++) begin
      a = addr + addr_t'(i);
      if (we) ref_mem[a] = wdata[8*i +: 8];
      else val[8*i +: 8] = ref_byte(a);
    end
    if (!we && !uns && size < 8 && val[8*size-1])
      for (int i = size; i < 8; i++) val[8*i +: 8] = 8'hFF;
    r.rdata = we ? 64'h0 : val;
    r.err = 1'b0;
    exp_rsp.push_back(r);

    @(negedge clk);
    req_addr = addr; req_op = op; req_we = we; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    budget = 0;
    while (!req_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      check_output("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      exp_beats.delete();
      exp_rsp.delete();
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
    if (wait_done) begin
      budget = 0;
      while ((exp_rsp.size() != 0 || exp_beats.size() != 0) && budget < 400) begin
        @(negedge clk);
        budget++;
      end
      if (exp_rsp.size() != 0 || exp_beats.size() != 0) begin
        check_output("completion_timeout", 0, 1);
        exp_beats.delete();
        exp_rsp.delete();
      end
    end
  endtask

  // Memory side: checks each accepted beat, keeps its own byte store, returns read lines.
  initial begin : mem_responder
    beat_t e;
    logic pend, pend_second, prev_hold, p_we;
    int cd, stall, stray_done;
    data_t pdata, p_wd;
    addr_t p_addr;
    be_t p_be;
    pend = 0; pend_second = 0; prev_hold = 0; p_we = 0;
    cd = 0; stall = 0; stray_done = 0;
    pdata = '0; p_wd = '0; p_addr = '0; p_be = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rst) begin
        exp_beats.delete();
        pend = 0; stall = 0; prev_hold = 0;
        mem_ready = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check_output("mem_hold_valid", mem_valid, 1);
        check_output("mem_hold_addr", mem_addr, p_addr);
        check_output("mem_hold_be", mem_be, p_be);
        check_output("mem_hold_we", mem_we, p_we);
        check_output("mem_hold_wdata", mem_wdata, p_wd);
      end
      if (mem_valid) check_output("req_ready_during_beat", req_ready, 0);
      if (stray_req != stray_done) begin
        mem_rvalid = 1'b1;
        mem_rdata = {$urandom, $urandom};
        stray_done++;
      end else if (pend) begin
        if (cd > 0) cd--;
        else if (!(hold_beat1 && pend_second)) begin
          mem_rvalid = 1'b1;
          mem_rdata = pdata;
          pend = 0;
        end
      end
      if (mem_valid && exp_beats.size() != 0 && exp_beats[0].second && stall < mem_stall_cfg) begin
        mem_ready = 1'b0;
        stall++;
      end else begin
        mem_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (mem_valid && mem_ready) begin
        stall = 0;
        prev_hold = 0;
        if (exp_beats.size() == 0) begin
          check_output("beat_unexpected", 1, 0);
        end else begin
          e = exp_beats.pop_front();
          check_output("beat_addr", mem_addr, e.addr);
          check_output("beat_we", mem_we, e.we);
          check_output("beat_be", mem_be, e.be);
          check_output("beat_wdata", mem_wdata, e.wdata);
          pend_second = e.second;
        end
        if (mem_we) begin
          for (int j = 0; j < 8; j++)
            if (mem_be[j]) sim_mem[mem_addr + addr_t'(j)] = mem_wdata[8*j +: 8];
        end else begin
          for (int j = 0; j < 8; j++) pdata[8*j +: 8] = sim_byte(mem_addr + addr_t'(j));
          pend = 1;
          cd = zero_wait ? 0 : $urandom_range(0, 2);
          if (pend_second) beat1_loads++;
        end
      end else begin
        prev_hold = mem_valid;
      end
      p_addr = mem_addr; p_be = mem_be; p_we = mem_we; p_wd = mem_wdata;
    end
  end

  // Response side: pops the scoreboard on each completion and checks stalled responses hold.
  initial begin : rsp_monitor
    rsp_t e;
    logic prev_hold, was_valid, prev_err;
    data_t prev_data;
    int stall;
    prev_hold = 0; was_valid = 0; prev_err = 0; prev_data = '0; stall = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_rsp.delete();
        prev_hold = 0; was_valid = 0; stall = 0;
        rsp_ready = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check_output("rsp_hold_valid", rsp_valid, 1);
        check_output("rsp_hold_rdata", rsp_rdata, prev_data);
        check_output("rsp_hold_err", rsp_err, prev_err);
      end
      if (rsp_valid && !was_valid) rsp_cyc = cyc;
      was_valid = rsp_valid;
      if (rsp_valid) check_output("req_ready_during_rsp", req_ready, 0);
      if (rsp_valid && stall < rsp_stall_cfg) begin
        rsp_ready = 1'b0;
        stall++;
      end else begin
        rsp_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid && rsp_ready) begin
        stall = 0;
        prev_hold = 0;
        if (exp_rsp.size() == 0) begin
          check_output("rsp_unexpected", 1, 0);
        end else begin
          e = exp_rsp.pop_front();
          check_output("rsp_rdata", rsp_rdata, e.rdata);
          check_output("rsp_err", rsp_err, e.err);
        end
      end else begin
        prev_hold = rsp_valid;
      end
      prev_data = rsp_rdata;
      prev_err = rsp_err;
    end
  end

  initial begin : nosplit_watch
    forever begin
      @(negedge clk);
      if (n_mem_valid) n_mem_seen = 1'b1;
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int budget;
    addr_t ra;
    req_valid = 1'b0; req_addr = '0; req_op = RW_BYTE; req_we = 1'b0;
    req_unsigned = 1'b0; req_wdata = '0;
    n_req_valid = 1'b0; n_req_addr = '0; n_req_op = RW_BYTE; n_req_we = 1'b0;
    n_req_wdata = '0; n_rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_output("reset_req_ready", req_ready, 1);
    check_output("reset_mem_valid", mem_valid, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_err_unexp", err_unexp, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed accesses");
    zero_wait = 1'b1;
    apply_stimulus(32'h1000, RW_DWORD, 1'b1, 1'b0, 64'h1122334455667788, 1'b1);
    apply_stimulus(32'h1000, RW_DWORD, 1'b0, 1'b0, 64'h0, 1'b1);
    // Aligned zero-wait load: response visible three cycles after the accept cycle.
    check_output("latency_aligned", rsp_cyc - acc_cyc, 2);
    apply_stimulus(32'h1006, RW_WORD, 1'b0, 1'b0, 64'h0, 1'b1);
    check_output("latency_split", rsp_cyc - acc_cyc, 4);
    zero_wait = 1'b0;

    apply_stimulus(32'h1000, RW_DWORD, 1'b1, 1'b0, 64'h0000000080000000, 1'b1);
    apply_stimulus(32'h1003, RW_BYTE, 1'b0, 1'b0, 64'h0, 1'b1);
    apply_stimulus(32'h1003, RW_BYTE, 1'b0, 1'b1, 64'h0, 1'b1);
    apply_stimulus(32'h1006, RW_WORD, 1'b1, 1'b0, 64'hAABBCCDD, 1'b1);
    apply_stimulus(32'h1006, RW_WORD, 1'b0, 1'b0, 64'h0, 1'b1);
    apply_stimulus(32'hFFFF_FFFF, RW_HALF, 1'b0, 1'b0, 64'h0, 1'b1);
    apply_stimulus(32'hFFFF_FFFC, RW_DWORD, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b1);
    apply_stimulus(32'hFFFF_FFFF, RW_HALF, 1'b0, 1'b1, 64'h0, 1'b1);

    mem_stall_cfg = 5;
    rsp_stall_cfg = 3;
    apply_stimulus(32'h100C, RW_DWORD, 1'b1, 1'b0, 64'hDEADBEEFCAFEF00D, 1'b1);
    apply_stimulus(32'h100D, RW_WORD, 1'b0, 1'b0, 64'h0, 1'b1);
    mem_stall_cfg = 0;
    rsp_stall_cfg = 0;

    $display("[TB] randomized accesses");
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) ra = 32'hFFFF_FFF0 + addr_t'($urandom_range(0, 15));
      else ra = 32'h1000 + addr_t'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      apply_stimulus(ra, rwop_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b1);
    end
    check_output("err_unexp_clean", err_unexp, 0);

    $display("[TB] reset during second read beat");
    hold_beat1 = 1'b1;
    budget = beat1_loads;
    apply_stimulus(32'h1006, RW_WORD, 1'b0, 1'b0, 64'h0, 1'b0);
    for (int w = 0; w < 100 && beat1_loads == budget; w++) @(negedge clk);
    check_output("wait1_reached", beat1_loads != budget, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_mem_valid", mem_valid, 0);
    check_output("rst_mem_be", mem_be, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_rdata", rsp_rdata, 0);
    hold_beat1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    stray_req++;
    repeat (3) @(negedge clk);
    #1;
    check_output("stray_err_unexp", err_unexp, 1);
    check_output("stray_req_ready", req_ready, 1);
    check_output("stray_no_beat", mem_valid, 0);
    apply_stimulus(32'h1006, RW_WORD, 1'b0, 1'b1, 64'h0, 1'b1);
    apply_stimulus(32'h1010, RW_HALF, 1'b1, 1'b0, 64'h5566, 1'b1);

    $display("[TB] split disabled instance");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_req_addr = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_1004;
      n_req_op = (k == 0) ? RW_HALF : RW_DWORD;
      n_req_we = (k == 1);
      n_req_wdata = 64'h1234_5678_9ABC_DEF0;
      n_req_valid = 1'b1;
      n_rsp_ready = 1'b0;
      check_output("nosplit_req_ready", n_req_ready, 1);
      @(posedge clk);
      #1 n_req_valid = 1'b0;
      budget = 0;
      @(negedge clk);
      while (!n_rsp_valid && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      check_output("nosplit_rsp_valid", n_rsp_valid, 1);
      check_output("nosplit_rsp_err", n_rsp_err, 1);
      check_output("nosplit_rsp_rdata", n_rsp_rdata, 0);
      check_output("nosplit_req_ready_busy", n_req_ready, 0);
      n_rsp_ready = 1'b1;
      @(negedge clk);
      check_output("nosplit_idle_again", n_req_ready, 1);
      n_rsp_ready = 1'b0;
    end
    check_output("nosplit_no_mem_beat", n_mem_seen, 0);

    repeat (3) @(negedge clk);
    check_output("queues_drained", exp_beats.size() + exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spmem_access_splitter.md
Name: spmem_access_splitter

Overview:
- Request front-end sitting directly upstream of the sparse memory model.
- Accepts one sized load/store (byte/half/word/dword, any byte alignment) from a core or testbench driver.
- Converts it into one or two 8-byte-aligned beats with byte enables on the memory port.
- Merges split read data and returns a single right-aligned, optionally sign-extended response.

Parameters:
AllowSplit, 1, 1 = accesses crossing an 8-byte boundary are split into two beats; 0 = such accesses complete immediately with rsp_err=1 and no memory access
(widths come from spmem_pkj: AddrWidth=32, DataWidth=64; not overridable here)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_addr  in  addr_t  byte address, any alignment
req_op  in  rwop_e  access size
req_we  in  1  1=store, 0=load
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_wdata  in  data_t  store data, right-aligned (bits [8*size-1:0] used)
rsp_valid  out  1  completion valid
rsp_ready  in  1  completion consumed
rsp_rdata  out  data_t  load result, extended to 64 bits; 0 for stores
rsp_err  out  1  misaligned-cross rejected (AllowSplit=0)
mem_valid  out  1  beat valid
mem_ready  in  1  beat accepted
mem_addr  out  addr_t  aligned beat address, [2:0]=0
mem_we  out  1  beat is write
mem_be  out  8  byte enables
mem_wdata  out  data_t  lane-positioned write data
mem_rvalid  in  1  read data return for the outstanding read beat
mem_rdata  in  data_t  read data, full 8-byte line
err_unexp  out  1  sticky: mem_rvalid seen outside a WAIT state

Behaviour:
- Reset (async, any time, including mid-split): state=IDLE, all outputs 0 except req_ready=1, captured data cleared, err_unexp cleared. No beat is reissued after reset.
- Decode at accept: size=1<<req_op; off=addr[2:0]; mask16=((1<<size)-1)<<off; wide=req_wdata<<(8*off) as 128 bits; cross=(off+size>8).
- Holding registers for addr, op, we, unsigned, mask16, wide, cross are loaded only on the req handshake.
- IDLE: req_ready=1. On handshake: if cross && !AllowSplit -> RESP with rsp_err=1; else -> ISSUE0.
- ISSUE0: mem_valid=1, mem_addr={addr[31:3],3'b000}, be=mask16[7:0], wdata=wide[63:0]. Outputs stable until mem_ready. On mem_ready: load -> WAIT0; store&&cross -> ISSUE1; store -> RESP.
- WAIT0: on mem_rvalid capture lo=mem_rdata; cross -> ISSUE1, else RESP.
- ISSUE1: mem_addr=aligned+8, wrapping 32 bits (0xFFFF_FFF8 -> 0x0000_0000); be=mask16[15:8]; wdata=wide[127:64]. On mem_ready: load -> WAIT1; store -> RESP.
- WAIT1: on mem_rvalid capture hi; -> RESP.
- RESP: rsp_valid=1 held with stable data until rsp_ready. On handshake -> IDLE.
  - Load data: r=({hi,lo}>>(8*off)) truncated to size bytes, then zero- or sign-extended to 64.
  - Store data: rsp_rdata=0.
- req_ready=0 in all non-IDLE states; strictly one access in flight, no overlap between the response and the next accept.
- mem_rvalid in any state other than WAIT0/WAIT1: ignored for data, sets err_unexp.
- Min latency, aligned load with 0-wait memory: accept T, ISSUE0 T+1, WAIT0 T+2 (rvalid same cycle), RESP T+3. A split load adds 2 cycles.
- DWORD at off=0 uses be=0xFF in a single beat. Byte accesses never split.

Decomposition:
- spmem_pkj gains: the beat state enum spsplit_state_e (IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP); localparam LineBytes=DataWidth/8; typedef logic [LineBytes-1:0] be_t.
- rwop_e, addr_t and data_t are reused unchanged.
- One natural sub-module: spmem_load_align (combinational extract + sign/zero extension of {hi,lo} by off/op/unsigned), reused later by the response path of other masters.

Test Plan:
- Aligned DWORD store then load at 0x1000, data 0x1122334455667788 -> one beat each, be=0xFF, addr 0x1000; load returns 0x1122334455667788.
- Signed byte load at 0x1003, line 0x00000000_80000000 -> be=0x08, rsp_rdata=0xFFFFFFFFFFFFFF80. Same with req_unsigned=1 -> 0x80.
- Split word store at 0x1006, data 0xAABBCCDD -> beat0 addr 0x1000 be=0xC0 wdata[63:48]=0xCCDD; beat1 addr 0x1008 be=0x03 wdata[15:0]=0xAABB. A following load returns 0xFFFFFFFFAABBCCDD.
- Wrap split: half load at 0xFFFF_FFFF -> beats at 0xFFFF_FFF8 (be=0x80) and 0x0000_0000 (be=0x01); merged correctly. With AllowSplit=0 -> rsp_err=1, no mem_valid ever asserted.
- Backpressure: mem_ready low 5 cycles in ISSUE1 and rsp_ready low 3 cycles in RESP -> mem and rsp outputs stable throughout, req_ready stays 0.
- Assert rst in WAIT1, then a stray mem_rvalid -> all outputs 0, req_ready=1, err_unexp=1 after the stray beat; the next access completes normally.
